// File: rtl/gs_sdram_arb.sv
// gs_sdram_arb: shares the General Sound SDRAM port between the ROM loader,
// GS Z80 memory cycles and refresh. Requests are captured as edge events into
// pending flags and served one command at a time (RF > LDR > WR > RD).
// Optional feature macro: GS_ARB_FORCE_RFSH_EN (forced refresh after RFSH_MAX
// cycles without one).
module gs_sdram_arb #(
  parameter int unsigned LDR_SEL_BIT = 31,
  parameter int unsigned LDR_AW      = 15,
  parameter int unsigned RFSH_MAX    = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        loader_act,
  input  logic [31:0] loader_a,
  input  logic [7:0]  loader_d,
  input  logic        loader_wr,
  output logic        ldr_busy,
  input  logic [20:0] gs_ma,
  input  logic [7:0]  gs_mdo,
  input  logic        gs_mrd_n,
  input  logic        gs_mwe_n,
  input  logic        gs_mrfsh_n,
  output logic [7:0]  gs_mdi,
  output logic        gs_done,
  output logic [24:0] sdr_a,
  output logic [7:0]  sdr_di,
  output logic        sdr_wr,
  output logic        sdr_rd,
  output logic        sdr_rfsh,
  input  logic [7:0]  sdr_do,
  input  logic        sdr_idle
);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WBUSY, ST_WIDLE, ST_DONE} state_t;
  typedef enum logic [1:0] {SEL_RF, SEL_LDR, SEL_WR, SEL_RD} sel_t;

  state_t              r_state, w_state_nxt;
  sel_t                r_sel, w_pick;
  logic                r_ldr_wr_q, r_mrd_q, r_mwe_q, r_mrfsh_q;
  logic                r_pend_rf, r_pend_ldr, r_pend_wr, r_pend_rd;
  logic [LDR_AW-1:0]   r_ldr_a;
  logic [7:0]          r_ldr_d;
  logic [1:0]          r_wcnt;
  logic                w_ev_ldr, w_ev_wr, w_ev_rd, w_ev_rf, w_force_rf;
  logic                w_any_pend, w_issue, w_finish;
  logic                w_clr_rf, w_clr_ldr, w_clr_wr, w_clr_rd;
  logic                w_unused;

  // Only the select bit and the forwarded low bits of loader_a matter.
  assign w_unused = ^loader_a;

  // Edge-detect history; loading it during reset means held levels make no event.
  always_ff @(posedge clk_sys) begin
    r_ldr_wr_q <= loader_wr;
    r_mrd_q    <= gs_mrd_n;
    r_mwe_q    <= gs_mwe_n;
    r_mrfsh_q  <= gs_mrfsh_n;
  end

  assign w_ev_ldr = loader_wr & ~r_ldr_wr_q & loader_act & loader_a[LDR_SEL_BIT];
  assign w_ev_rd  = ~gs_mrd_n & r_mrd_q & ~loader_act;
  assign w_ev_wr  = ~gs_mwe_n & r_mwe_q & ~loader_act;
  assign w_ev_rf  = (~gs_mrfsh_n & r_mrfsh_q & ~loader_act) | w_force_rf;

`ifdef GS_ARB_FORCE_RFSH_EN
  localparam int unsigned RCW = $clog2(RFSH_MAX);
  logic [RCW-1:0] r_rcnt;

  // Cycles since the last issued refresh, saturating at RFSH_MAX-1.
  always_ff @(posedge clk_sys) begin
    if (reset || w_clr_rf) begin
      r_rcnt <= '0;
    end else if (r_rcnt != RCW'(RFSH_MAX - 1)) begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end

  // Gated by the pending flag so a single forced request is raised per interval.
  assign w_force_rf = (r_rcnt == RCW'(RFSH_MAX - 1)) & ~r_pend_rf;
`else
  assign w_force_rf = 1'b0;
`endif

  assign w_any_pend = r_pend_rf | r_pend_ldr | r_pend_wr | r_pend_rd;
  assign ldr_busy   = r_pend_ldr | ((r_state != ST_IDLE) && (r_sel == SEL_LDR));

  // Fixed-priority pick among pending requests.
  always_comb begin
    w_pick = SEL_RD;
    if (r_pend_rf)       w_pick = SEL_RF;
    else if (r_pend_ldr) w_pick = SEL_LDR;
    else if (r_pend_wr)  w_pick = SEL_WR;
  end

  // Next-state logic for the command sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_pend && sdr_idle) begin
          w_state_nxt = ST_ISSUE;
          w_issue     = 1'b1;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WBUSY;
      ST_WBUSY: begin
        if (!sdr_idle || (r_wcnt == 2'd3)) w_state_nxt = ST_WIDLE;
      end
      ST_WIDLE: begin
        if (sdr_idle) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clr_rf  = w_issue && (w_pick == SEL_RF);
  assign w_clr_ldr = w_issue && (w_pick == SEL_LDR);
  assign w_clr_wr  = w_issue && (w_pick == SEL_WR);
  assign w_clr_rd  = w_issue && (w_pick == SEL_RD);

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Command pulses, address/data and flag clears are registered on the edge
  // entering ISSUE, so they are visible for exactly the ISSUE cycle; likewise
  // gs_done/gs_mdi are loaded on the edge entering DONE.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_pend_rf  <= 1'b0;
      r_pend_ldr <= 1'b0;
      r_pend_wr  <= 1'b0;
      r_pend_rd  <= 1'b0;
      r_ldr_a    <= '0;
      r_ldr_d    <= '0;
      r_sel      <= SEL_RF;
      r_wcnt     <= '0;
      sdr_a      <= '0;
      sdr_di     <= '0;
      sdr_wr     <= 1'b0;
      sdr_rd     <= 1'b0;
      sdr_rfsh   <= 1'b0;
      gs_done    <= 1'b0;
      gs_mdi     <= '0;
    end else begin
      sdr_wr   <= 1'b0;
      sdr_rd   <= 1'b0;
      sdr_rfsh <= 1'b0;
      gs_done  <= 1'b0;

      // A new event wins over a same-cycle clear so it is never lost.
      r_pend_rf  <= w_ev_rf  | (r_pend_rf  & ~w_clr_rf);
      r_pend_ldr <= w_ev_ldr | (r_pend_ldr & ~w_clr_ldr);
      r_pend_wr  <= w_ev_wr  | (r_pend_wr  & ~w_clr_wr);
      r_pend_rd  <= w_ev_rd  | (r_pend_rd  & ~w_clr_rd);

      if (w_ev_ldr) begin
        r_ldr_a <= loader_a[LDR_AW-1:0];
        r_ldr_d <= loader_d;
      end

      if (r_state == ST_WBUSY) r_wcnt <= r_wcnt + 1'b1;
      else                     r_wcnt <= '0;

      if (w_issue) begin
        r_sel <= w_pick;
        case (w_pick)
          SEL_RF:  sdr_rfsh <= 1'b1;
          SEL_LDR: begin
            sdr_wr <= 1'b1;
            sdr_a  <= 25'(r_ldr_a);
            sdr_di <= r_ldr_d;
          end
          SEL_WR: begin
            sdr_wr <= 1'b1;
            sdr_a  <= {4'b0, gs_ma};
            sdr_di <= gs_mdo;
          end
          default: begin
            sdr_rd <= 1'b1;
            sdr_a  <= {4'b0, gs_ma};
          end
        endcase
      end

      if (w_finish) begin
        if (r_sel == SEL_RD) gs_mdi <= sdr_do;
        gs_done <= (r_sel == SEL_RD) || (r_sel == SEL_WR);
      end
    end
  end

endmodule

// File: tb/tb_gs_sdram_arb.sv
// Testbench for gs_sdram_arb: controller model plus command/done scoreboards.
module tb_gs_sdram_arb;

  localparam int BUSY = 3;
  localparam logic [1:0] K_WR = 2'd1, K_RD = 2'd2, K_RF = 2'd3;
`ifdef GS_ARB_FORCE_RFSH_EN
  localparam int unsigned RM = 16;
`else
  localparam int unsigned RM = 1024;
`endif

  typedef struct {
    logic [1:0]  k;
    logic [24:0] a;
    logic [7:0]  d;
    bit          ca;
    bit          cd;
  } cmd_t;

  logic        clk_sys = 1'b0;
  logic        reset, loader_act, loader_wr, ldr_busy;
  logic [31:0] loader_a;
  logic [7:0]  loader_d, gs_mdo, gs_mdi, sdr_di;
  logic [20:0] gs_ma;
  logic        gs_mrd_n, gs_mwe_n, gs_mrfsh_n, gs_done;
  logic [24:0] sdr_a;
  logic        sdr_wr, sdr_rd, sdr_rfsh;
  logic [7:0]  sdr_do = 8'h00;
  logic        sdr_idle = 1'b1;

  int          tests = 0;
  int          fails = 0;
  int          viol = 0;
  int          busy_cnt = 0;
  bit          rd_pend = 0;
  logic [24:0] rd_addr;
  logic [7:0]  rd_default = 8'hEE;
  logic [7:0]  mem [logic [24:0]];
  cmd_t        q_exp[$];
  cmd_t        q_obs[$];
  logic [7:0]  q_exp_done[$];
  logic [7:0]  q_done[$];

  always #5 clk_sys = ~clk_sys;

  gs_sdram_arb #(.LDR_SEL_BIT(31), .LDR_AW(15), .RFSH_MAX(RM)) dut (
    .clk_sys(clk_sys), .reset(reset), .loader_act(loader_act), .loader_a(loader_a),
    .loader_d(loader_d), .loader_wr(loader_wr), .ldr_busy(ldr_busy), .gs_ma(gs_ma),
    .gs_mdo(gs_mdo), .gs_mrd_n(gs_mrd_n), .gs_mwe_n(gs_mwe_n), .gs_mrfsh_n(gs_mrfsh_n),
    .gs_mdi(gs_mdi), .gs_done(gs_done), .sdr_a(sdr_a), .sdr_di(sdr_di), .sdr_wr(sdr_wr),
    .sdr_rd(sdr_rd), .sdr_rfsh(sdr_rfsh), .sdr_do(sdr_do), .sdr_idle(sdr_idle)
  );

  // SDRAM controller model and output monitor, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (sdr_wr === 1'b1 || sdr_rd === 1'b1 || sdr_rfsh === 1'b1) begin
      if (busy_cnt != 0 || !sdr_idle) viol++;
      if ($countones({sdr_wr, sdr_rd, sdr_rfsh}) != 1) viol++;
      q_obs.push_back('{sdr_wr ? K_WR : (sdr_rd ? K_RD : K_RF), sdr_a, sdr_di, 1'b1, 1'b1});
      if (sdr_wr) mem[sdr_a] = sdr_di;
      if (sdr_rd) begin
        rd_addr = sdr_a;
        rd_pend = 1;
      end
      busy_cnt = BUSY;
      sdr_idle = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        if (rd_pend) sdr_do = mem.exists(rd_addr) ? mem[rd_addr] : rd_default;
        rd_pend  = 0;
        sdr_idle = 1'b1;
      end
    end
    if (gs_done === 1'b1) q_done.push_back(gs_mdi);
  end

  task automatic test_reset();
    reset = 1; loader_act = 0; loader_wr = 0; loader_a = '0; loader_d = '0;
    gs_ma = '0; gs_mdo = '0; gs_mrd_n = 0; gs_mwe_n = 1; gs_mrfsh_n = 1;
    repeat (3) @(posedge clk_sys);
    #1;
    tests++;
    if ({sdr_wr, sdr_rd, sdr_rfsh, gs_done, ldr_busy} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {sdr_wr, sdr_rd, sdr_rfsh, gs_done, ldr_busy});
    end
    tests++;
    if (gs_mdi !== 8'h00) begin fails++; $display("FAIL reset_mdi: got %h expected 00", gs_mdi); end
    tests++;
    if (sdr_a !== 25'h0 || sdr_di !== 8'h00) begin
      fails++; $display("FAIL reset_sdr_a_di: got %h/%h expected 0/0", sdr_a, sdr_di);
    end
    // gs_mrd_n held low through reset must not produce a read.
    reset = 0;
    repeat (10) @(posedge clk_sys);
    #1;
    tests++;
    if (q_obs.size() != 0) begin fails++; $display("FAIL reset_quiet: got %0d commands expected 0", q_obs.size()); end
    q_obs.delete();
    gs_mrd_n = 1;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic test_loader_write();
    cmd_t e, o;
    int   n;
    loader_act = 1; loader_a = 32'h8000_1234; loader_d = 8'hA5; loader_wr = 1;
    q_exp.push_back('{K_WR, 25'h0001234, 8'hA5, 1'b1, 1'b1});
    @(posedge clk_sys); #1;
    loader_wr = 0;
    tests++;
    if (ldr_busy !== 1'b1) begin fails++; $display("FAIL ldr_busy_set: got %b expected 1", ldr_busy); end
    n = 0;
    while (ldr_busy === 1'b1 && n < 60) begin
      @(posedge clk_sys); #1; n++;
    end
    tests++;
    if (ldr_busy !== 1'b0) begin fails++; $display("FAIL ldr_busy_clear: got %b expected 0 within 60 cycles", ldr_busy); end
    tests++;
    if (q_obs.size() != q_exp.size()) begin fails++; $display("FAIL ldr_cmd_count: got %0d expected %0d", q_obs.size(), q_exp.size()); end
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o.k !== e.k || (e.ca && o.a !== e.a) || (e.cd && o.d !== e.d)) begin
        fails++; $display("FAIL ldr_cmd: got k=%0d a=%h d=%h expected k=%0d a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d);
      end
    end
    q_exp.delete(); q_obs.delete();
    tests++;
    if (q_done.size() != 0) begin fails++; $display("FAIL ldr_no_done: got %0d gs_done expected 0", q_done.size()); end
    q_done.delete();
  endtask

  task automatic test_loader_nosel();
    bit seen;
    loader_a = 32'h0000_1234; loader_d = 8'h77; loader_wr = 1;
    @(posedge clk_sys); #1;
    loader_wr = 0;
    seen = ldr_busy;
    repeat (20) begin @(posedge clk_sys); #1; seen |= ldr_busy; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL nosel_busy: got %b expected 0", seen); end
    tests++;
    if (q_obs.size() != 0) begin fails++; $display("FAIL nosel_cmd: got %0d commands expected 0", q_obs.size()); end
    q_obs.delete();
    loader_act = 0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_gs_read();
    cmd_t e, o;
    int   n;
    rd_default = 8'h3C; gs_ma = 21'h1F_0010; gs_mrd_n = 0;
    q_exp.push_back('{K_RD, 25'h01F0010, 8'h00, 1'b1, 1'b0});
    q_exp_done.push_back(8'h3C);
    n = 0;
    while (gs_done !== 1'b1 && n < 40) begin @(posedge clk_sys); #1; n++; end
    tests++;
    if (n != 2 + BUSY + 1) begin fails++; $display("FAIL rd_latency: got %0d cycles expected %0d", n, 2 + BUSY + 1); end
    repeat (5) @(posedge clk_sys);
    #1;
    gs_mrd_n = 1;
    tests++;
    if (q_obs.size() != q_exp.size()) begin fails++; $display("FAIL rd_cmd_count: got %0d expected %0d", q_obs.size(), q_exp.size()); end
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o.k !== e.k || (e.ca && o.a !== e.a) || (e.cd && o.d !== e.d)) begin
        fails++; $display("FAIL rd_cmd: got k=%0d a=%h expected k=%0d a=%h", o.k, o.a, e.k, e.a);
      end
    end
    tests++;
    if (q_done.size() != q_exp_done.size()) begin fails++; $display("FAIL rd_done_count: got %0d expected %0d", q_done.size(), q_exp_done.size()); end
    while (q_exp_done.size() > 0 && q_done.size() > 0) begin
      tests++;
      if (q_done[0] !== q_exp_done[0]) begin fails++; $display("FAIL rd_mdi: got %h expected %h", q_done[0], q_exp_done[0]); end
      void'(q_done.pop_front()); void'(q_exp_done.pop_front());
    end
    q_exp.delete(); q_obs.delete(); q_done.delete(); q_exp_done.delete();
  endtask

  task automatic test_simultaneous();
    cmd_t e, o;
    int   n;
    gs_ma = 21'h00_0ABC; gs_mdo = 8'h5A; gs_mrfsh_n = 0; gs_mwe_n = 0;
    q_exp.push_back('{K_RF, 25'h0, 8'h00, 1'b0, 1'b0});
    q_exp.push_back('{K_WR, 25'h0000ABC, 8'h5A, 1'b1, 1'b1});
    q_exp_done.push_back(8'h3C);
    n = 0;
    while (q_done.size() < 1 && n < 60) begin @(posedge clk_sys); #1; n++; end
    repeat (5) @(posedge clk_sys);
    #1;
    gs_mrfsh_n = 1; gs_mwe_n = 1;
    tests++;
    if (q_obs.size() != q_exp.size()) begin fails++; $display("FAIL sim_cmd_count: got %0d expected %0d", q_obs.size(), q_exp.size()); end
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o.k !== e.k || (e.ca && o.a !== e.a) || (e.cd && o.d !== e.d)) begin
        fails++; $display("FAIL sim_cmd: got k=%0d a=%h d=%h expected k=%0d a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d);
      end
    end
    tests++;
    if (q_done.size() != q_exp_done.size()) begin fails++; $display("FAIL sim_done_count: got %0d expected %0d", q_done.size(), q_exp_done.size()); end
    while (q_exp_done.size() > 0 && q_done.size() > 0) begin
      tests++;
      if (q_done[0] !== q_exp_done[0]) begin fails++; $display("FAIL sim_mdi_hold: got %h expected %h", q_done[0], q_exp_done[0]); end
      void'(q_done.pop_front()); void'(q_exp_done.pop_front());
    end
    q_exp.delete(); q_obs.delete(); q_done.delete(); q_exp_done.delete();
  endtask

  task automatic test_masked();
    loader_act = 1; loader_a = 32'h0; gs_ma = 21'h00_0042;
    @(posedge clk_sys); #1;
    gs_mrd_n = 0; gs_mwe_n = 0; gs_mrfsh_n = 0;
    repeat (15) @(posedge clk_sys);
    #1;
    tests++;
    if (q_obs.size() != 0 || q_done.size() != 0) begin
      fails++; $display("FAIL masked: got %0d cmds %0d dones expected 0/0", q_obs.size(), q_done.size());
    end
    gs_mrd_n = 1; gs_mwe_n = 1; gs_mrfsh_n = 1;
    @(posedge clk_sys); #1;
    loader_act = 0;
    q_obs.delete(); q_done.delete();
  endtask

  task automatic test_back_to_back();
    logic [20:0] addrs [4];
    logic [7:0]  datas [4];
    logic [7:0]  last_rd;
    cmd_t        e, o;
    bit          is_rd;
    int          idx, n;
    addrs = '{21'h00_0100, 21'h1F_FFFF, 21'h0A_BCDE, 21'h10_0000};
    datas = '{8'h11, 8'hFF, 8'h00, 8'hC3};
    last_rd = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      is_rd = (i >= 4);
      idx = i % 4;
      gs_ma = addrs[idx]; gs_mdo = datas[idx];
      if (is_rd) gs_mrd_n = 0; else gs_mwe_n = 0;
      q_exp.push_back('{is_rd ? K_RD : K_WR, {4'b0, addrs[idx]}, datas[idx], 1'b1, !is_rd});
      if (is_rd) last_rd = datas[idx];
      q_exp_done.push_back(last_rd);
      n = 0;
      while (q_done.size() < i + 1 && n < 40) begin @(posedge clk_sys); #1; n++; end
      gs_mrd_n = 1; gs_mwe_n = 1;
      @(posedge clk_sys); #1;
    end
    tests++;
    if (q_obs.size() != q_exp.size()) begin fails++; $display("FAIL b2b_cmd_count: got %0d expected %0d", q_obs.size(), q_exp.size()); end
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); tests++;
      if (o.k !== e.k || (e.ca && o.a !== e.a) || (e.cd && o.d !== e.d)) begin
        fails++; $display("FAIL b2b_cmd: got k=%0d a=%h d=%h expected k=%0d a=%h d=%h", o.k, o.a, o.d, e.k, e.a, e.d);
      end
    end
    tests++;
    if (q_done.size() != q_exp_done.size()) begin fails++; $display("FAIL b2b_done_count: got %0d expected %0d", q_done.size(), q_exp_done.size()); end
    while (q_exp_done.size() > 0 && q_done.size() > 0) begin
      tests++;
      if (q_done[0] !== q_exp_done[0]) begin fails++; $display("FAIL b2b_mdi: got %h expected %h", q_done[0], q_exp_done[0]); end
      void'(q_done.pop_front()); void'(q_exp_done.pop_front());
    end
    q_exp.delete(); q_obs.delete(); q_done.delete(); q_exp_done.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    gs_ma = 21'h00_0777; gs_mrd_n = 0;
    n = 0;
    while (q_obs.size() < 1 && n < 40) begin @(posedge clk_sys); #1; n++; end
    tests++;
    if (q_obs.size() != 1 || q_obs[0].k !== K_RD || q_obs[0].a !== 25'h0000777) begin
      fails++; $display("FAIL midrst_cmd: got %0d cmds expected 1 read at 0000777", q_obs.size());
    end
    reset = 1;
    gs_mrd_n = 1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 0;
    repeat (15) @(posedge clk_sys);
    #1;
    tests++;
    if (q_done.size() != 0) begin fails++; $display("FAIL midrst_no_done: got %0d gs_done expected 0", q_done.size()); end
    tests++;
    if (gs_mdi !== 8'h00) begin fails++; $display("FAIL midrst_mdi: got %h expected 00", gs_mdi); end
    q_obs.delete(); q_done.delete();
  endtask

  task automatic test_refresh_idle();
    int rf;
    repeat (60) @(posedge clk_sys);
    #1;
    rf = 0;
    foreach (q_obs[i]) if (q_obs[i].k == K_RF) rf++;
    tests++;
`ifdef GS_ARB_FORCE_RFSH_EN
    if (rf < 2) begin fails++; $display("FAIL forced_rfsh: got %0d refreshes expected >=2", rf); end
`else
    if (q_obs.size() != 0) begin fails++; $display("FAIL idle_no_rfsh: got %0d commands expected 0", q_obs.size()); end
`endif
    q_obs.delete();
  endtask

  initial begin
    test_reset();
    test_loader_write();
    test_loader_nosel();
    test_gs_read();
    test_simultaneous();
    test_masked();
    test_back_to_back();
    test_reset_mid();
    test_refresh_idle();
    tests++;
    if (viol != 0) begin fails++; $display("FAIL protocol: got %0d violations expected 0", viol); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
